// File: rtl/gray_counter.sv
// Up/down binary counter with registered binary and reflected-Gray outputs, load in
// either format, and a one-cycle wrap pulse; intended as an async-FIFO pointer source.
module gray_counter #(
    parameter int                      p_DATA_WIDTH  = 32,
    parameter logic [p_DATA_WIDTH-1:0] p_RESET_VALUE = '0
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_en,
    input  logic                    i_dir,
    input  logic                    i_load,
    input  logic                    i_load_sel,
    input  logic [p_DATA_WIDTH-1:0] i_load_val,
    output logic [p_DATA_WIDTH-1:0] o_bin,
    output logic [p_DATA_WIDTH-1:0] o_gray,
    output logic [p_DATA_WIDTH-1:0] o_bin_next,
    output logic [p_DATA_WIDTH-1:0] o_gray_next,
    output logic                    o_wrap
);

    localparam int               W          = p_DATA_WIDTH;
    localparam logic [W-1:0]     ONE        = W'(1);
    localparam logic [W-1:0]     ALL_ONES   = '1;
    localparam logic [W-1:0]     RESET_GRAY = p_RESET_VALUE ^ (p_RESET_VALUE >> 1);

    function automatic logic [W-1:0] bin_to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [W-1:0] bin_next;
    logic [W-1:0] gray_next;
    logic         wrap_next;

    // Next-state selection: reset > load > count > hold.
    always_comb begin
        bin_next  = o_bin;
        wrap_next = 1'b0;
        if (i_rst) begin
            bin_next = p_RESET_VALUE;
        end else if (i_load) begin
            bin_next = i_load_sel ? gray_to_bin(i_load_val) : i_load_val;
        end else if (i_en) begin
            if (i_dir) begin
                bin_next  = o_bin + ONE;
                wrap_next = (o_bin == ALL_ONES);
            end else begin
                bin_next  = o_bin - ONE;
                wrap_next = (o_bin == '0);
            end
        end
    end

    // Gray is encoded before the flop so o_gray never glitches across domains.
    assign gray_next   = bin_to_gray(bin_next);
    assign o_bin_next  = bin_next;
    assign o_gray_next = gray_next;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_bin  <= p_RESET_VALUE;
            o_gray <= RESET_GRAY;
            o_wrap <= 1'b0;
        end else begin
            o_bin  <= bin_next;
            o_gray <= gray_next;
            o_wrap <= wrap_next;
        end
    end

endmodule

// File: tb/tb_gray_counter.sv
// Scoreboard bench for gray_counter: three instances (W=4, W=8 reset 5, W=16) driven
// one at a time against an independent behavioural model.
module tb_gray_counter;

    typedef struct packed {
        logic [15:0] bin;
        logic        wrap;
    } exp_t;

    logic        i_clk;
    logic        rst  [3];
    logic        en   [3];
    logic        dir  [3];
    logic        load [3];
    logic        sel  [3];
    logic [15:0] val  [3];

    logic [3:0]  bin4,  gray4,  binn4,  grayn4;
    logic [7:0]  bin8,  gray8,  binn8,  grayn8;
    logic [15:0] bin16, gray16, binn16, grayn16;
    logic        wrap4, wrap8, wrap16;

    logic [15:0] obin[3], ogray[3], obinn[3], ograyn[3];
    logic        owrap[3];

    int          checks   = 0;
    int          failures = 0;
    exp_t        sb[$];
    logic [15:0] mstate[3];
    int          wid[3]  = '{4, 8, 16};
    logic [15:0] rval[3] = '{16'd0, 16'd5, 16'd0};
    logic [3:0]  gray_tbl[17] = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                                  4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};

    gray_counter #(.p_DATA_WIDTH(4), .p_RESET_VALUE(4'd0)) u_dut4 (
        .i_clk(i_clk), .i_rst(rst[0]), .i_en(en[0]), .i_dir(dir[0]), .i_load(load[0]),
        .i_load_sel(sel[0]), .i_load_val(val[0][3:0]), .o_bin(bin4), .o_gray(gray4),
        .o_bin_next(binn4), .o_gray_next(grayn4), .o_wrap(wrap4));

    gray_counter #(.p_DATA_WIDTH(8), .p_RESET_VALUE(8'd5)) u_dut8 (
        .i_clk(i_clk), .i_rst(rst[1]), .i_en(en[1]), .i_dir(dir[1]), .i_load(load[1]),
        .i_load_sel(sel[1]), .i_load_val(val[1][7:0]), .o_bin(bin8), .o_gray(gray8),
        .o_bin_next(binn8), .o_gray_next(grayn8), .o_wrap(wrap8));

    gray_counter #(.p_DATA_WIDTH(16), .p_RESET_VALUE(16'd0)) u_dut16 (
        .i_clk(i_clk), .i_rst(rst[2]), .i_en(en[2]), .i_dir(dir[2]), .i_load(load[2]),
        .i_load_sel(sel[2]), .i_load_val(val[2]), .o_bin(bin16), .o_gray(gray16),
        .o_bin_next(binn16), .o_gray_next(grayn16), .o_wrap(wrap16));

    assign obin[0]   = {12'd0, bin4};
    assign ogray[0]  = {12'd0, gray4};
    assign obinn[0]  = {12'd0, binn4};
    assign ograyn[0] = {12'd0, grayn4};
    assign owrap[0]  = wrap4;
    assign obin[1]   = {8'd0, bin8};
    assign ogray[1]  = {8'd0, gray8};
    assign obinn[1]  = {8'd0, binn8};
    assign ograyn[1] = {8'd0, grayn8};
    assign owrap[1]  = wrap8;
    assign obin[2]   = bin16;
    assign ogray[2]  = gray16;
    assign obinn[2]  = binn16;
    assign ograyn[2] = grayn16;
    assign owrap[2]  = wrap16;

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Gray-to-binary as an XOR of all right shifts, independent of the MSB-first chain.
    function automatic logic [15:0] ref_g2b(input logic [15:0] g);
        logic [15:0] b = '0;
        for (int k = 0; k < 16; k++) b ^= (g >> k);
        return b;
    endfunction

    function automatic exp_t ref_step(input int d, input logic r, input logic ld,
                                      input logic s, input logic [15:0] v,
                                      input logic e, input logic up);
        exp_t        x;
        logic [15:0] mask = 16'hFFFF >> (16 - wid[d]);
        logic [15:0] cur  = mstate[d];
        x.wrap = 1'b0;
        x.bin  = cur;
        if (r) x.bin = rval[d];
        else if (ld) x.bin = s ? ref_g2b(v & mask) : (v & mask);
        else if (e) begin
            if (up) begin
                x.bin  = (cur + 16'd1) & mask;
                x.wrap = (cur == mask);
            end else begin
                x.bin  = (cur - 16'd1) & mask;
                x.wrap = (cur == 16'd0);
            end
        end
        return x;
    endfunction

    // One clock of stimulus on DUT d; other instances sit idle and hold.
    task automatic cycle(input int d, input logic r, input logic ld, input logic s,
                         input logic [15:0] v, input logic e, input logic up);
        exp_t        x;
        exp_t        got;
        logic [15:0] prev_gray;
        logic        count_only;
        @(negedge i_clk);
        rst[d] = r; load[d] = ld; sel[d] = s; val[d] = v; en[d] = e; dir[d] = up;
        x = ref_step(d, r, ld, s, v, e, up);
        count_only = !r && !ld && e;
        #1;
        check_eq("bin_next", 32'(obinn[d]), 32'(x.bin));
        check_eq("gray_next", 32'(ograyn[d]), 32'(x.bin ^ (x.bin >> 1)));
        sb.push_back(x);
        mstate[d] = x.bin;
        prev_gray = ogray[d];
        @(posedge i_clk);
        #1;
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd1, 32'd0);
        end else begin
            got = sb.pop_front();
            check_eq("bin", 32'(obin[d]), 32'(got.bin));
            check_eq("gray", 32'(ogray[d]), 32'(got.bin ^ (got.bin >> 1)));
            check_eq("wrap", 32'(owrap[d]), 32'(got.wrap));
            if (count_only)
                check_eq("gray_1bit", 32'($countones(ogray[d] ^ prev_gray) <= 1), 32'd1);
        end
        rst[d] = 1'b0; load[d] = 1'b0; en[d] = 1'b0;
    endtask

    initial begin
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b0; en[d] = 1'b0; dir[d] = 1'b0;
            load[d] = 1'b0; sel[d] = 1'b0; val[d] = '0; mstate[d] = '0;
        end
        for (int d = 0; d < 3; d++) cycle(d, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        check_eq("rst4_bin", 32'(bin4), 32'h0);
        check_eq("rst8_bin", 32'(bin8), 32'h5);
        check_eq("rst8_gray", 32'(gray8), 32'h7);

        // W=4 full up sweep with Gray sequence table.
        for (int i = 1; i <= 16; i++) begin
            cycle(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
            check_eq("t1_gray_tbl", 32'(gray4), 32'(gray_tbl[i]));
            check_eq("t1_wrap", 32'(wrap4), (i == 16) ? 32'd1 : 32'd0);
        end

        // Down-wrap from 0, then alternate direction at the boundary.
        cycle(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        check_eq("t2_bin", 32'(bin4), 32'hF);
        check_eq("t2_gray", 32'(gray4), 32'h8);
        check_eq("t2_wrap", 32'(wrap4), 32'd1);
        cycle(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        check_eq("t2b_bin", 32'(bin4), 32'hE);
        check_eq("t2b_gray", 32'(gray4), 32'h9);
        check_eq("t2b_wrap", 32'(wrap4), 32'd0);
        cycle(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        cycle(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        check_eq("alt_up_wrap", 32'(wrap4), 32'd1);
        cycle(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
        check_eq("alt_dn_wrap", 32'(wrap4), 32'd1);
        cycle(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        check_eq("alt_up_wrap2", 32'(wrap4), 32'd1);

        // Gray load wins over count; load of all-ones never pulses wrap.
        cycle(1, 1'b0, 1'b1, 1'b1, 16'h00C0, 1'b1, 1'b1);
        check_eq("t3_bin", 32'(bin8), 32'h80);
        check_eq("t3_gray", 32'(gray8), 32'hC0);
        check_eq("t3_wrap", 32'(wrap8), 32'd0);
        cycle(1, 1'b0, 1'b1, 1'b0, 16'h00FF, 1'b0, 1'b1);
        cycle(1, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1);
        check_eq("load_no_wrap", 32'(wrap8), 32'd0);

        // Reset overrides an active count.
        cycle(1, 1'b0, 1'b1, 1'b0, 16'h007F, 1'b0, 1'b0);
        @(negedge i_clk);
        rst[1] = 1'b1; en[1] = 1'b1; dir[1] = 1'b1;
        #1;
        check_eq("t4_bin_next", 32'(binn8), 32'h5);
        rst[1] = 1'b0; en[1] = 1'b0;
        cycle(1, 1'b1, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        check_eq("t4_bin", 32'(bin8), 32'h5);
        check_eq("t4_gray", 32'(gray8), 32'h7);
        check_eq("t4_wrap", 32'(wrap8), 32'd0);

        // Count to 9 then hold.
        cycle(0, 1'b1, 1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) cycle(0, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            cycle(0, 1'b0, 1'b0, 1'b0, 16'h5, 1'b0, 1'b0);
            check_eq("t6_bin", 32'(bin4), 32'h9);
            check_eq("t6_gray", 32'(gray4), 32'hD);
            check_eq("t6_wrap", 32'(wrap4), 32'd0);
            check_eq("t6_bin_next", 32'(binn4), 32'h9);
        end

        // W=16 random traffic.
        for (int i = 0; i < 10000; i++) begin
            logic r, ld;
            r  = ($urandom_range(0, 199) == 0);
            ld = ($urandom_range(0, 9) == 0);
            cycle(2, r, ld, 1'($urandom_range(0, 1)), 16'($urandom),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
            check_eq("t5_gray_inv", 32'(gray16), 32'(bin16 ^ (bin16 >> 1)));
        end
        // Force a wrap on the wide instance.
        cycle(2, 1'b0, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b0);
        cycle(2, 1'b0, 1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
        check_eq("t5_wrap16", 32'(wrap16), 32'd1);

        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
